// File: rtl/ysyx_22041071_wb_stage_pkg.sv
// Shared definitions for the write-back stage: datapath sizes, halt encoding,
// FSM state type and the ABI index of a0 used for the good-trap test.
package ysyx_22041071_wb_stage_pkg;

   localparam int          XLEN       = 64;
   localparam int          NREG       = 32;
   localparam logic [31:0] EBREAK_INS = 32'h0010_0073;
   localparam logic [4:0]  REG_A0     = 5'd10;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } wb_state_e;

endpackage

// File: rtl/ysyx_22041071_wb_stage_regfile.sv
// Integer register file: one write port, two write-first bypassed read ports,
// plus a bypassed a0 tap for the ebreak good-trap decision. x0 reads as zero.
module ysyx_22041071_regfile
   import ysyx_22041071_wb_stage_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] a0_data
);

   logic [XLEN-1:0] rf [NREG];

   // NOTE: sequential state always uses <= so every flop samples pre-edge values.
   // NOTE: the array is cleared on reset so every register reads a defined 0 afterwards.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (we && waddr != 5'd0) begin
         rf[waddr] <= wdata;
      end
   end

   // NOTE: each combinational output gets a default first, so no path infers a latch.
   always_comb begin
      rs1_data = rf[rs1_addr];
      if (rs1_addr == 5'd0) rs1_data = '0;
      else if (we && waddr == rs1_addr) rs1_data = wdata;
   end

   always_comb begin
      rs2_data = rf[rs2_addr];
      if (rs2_addr == 5'd0) rs2_data = '0;
      else if (we && waddr == rs2_addr) rs2_data = wdata;
   end

   always_comb begin
      a0_data = rf[REG_A0];
      if (we && waddr == REG_A0) a0_data = wdata;
   end

endmodule

// File: rtl/ysyx_22041071_wb_stage.sv
// Write-back stage: register file, commit record, counters and ebreak halt FSM.
// Optional commit watchdog enabled by defining YSYX_22041071_WB_TIMEOUT_EN.
module ysyx_22041071_wb_stage
  import ysyx_22041071_wb_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
)
(
  input  logic            clk,
  input  logic            reset,
  input  logic            valid6,
  output logic            ready6,
  input  logic [XLEN-1:0] PC6,
  input  logic [31:0]     Ins5,
  input  logic            reg_w_en4,
  input  logic [4:0]      rdest3,
  input  logic [XLEN-1:0] WB_data1,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic [31:0]     commit_ins,
  output logic            commit_wen,
  output logic [4:0]      commit_rd,
  output logic [XLEN-1:0] commit_data,
  output logic            halt,
  output logic            good_trap,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret,
  output logic            timeout
);

  wb_state_e       state_q, state_d;
  logic            hs;
  logic            ebreak_hit;
  logic            idle_expire;
  logic [XLEN-1:0] a0_data;

  assign ready6 = (state_q == RUN);
  assign hs     = valid6 & ready6;

  ysyx_22041071_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (hs & reg_w_en4),
    .waddr    (rdest3),
    .wdata    (WB_data1),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .a0_data  (a0_data)
  );

`ifdef YSYX_22041071_WB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [IDLE_W-1:0] idle_cnt;

  // An accepted instruction on the limit cycle wins over the watchdog.
  assign idle_expire = (state_q == RUN) && !hs &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (hs)                  idle_cnt <= '0;
      else if (state_q == RUN) idle_cnt <= idle_cnt + IDLE_W'(1);
      if (idle_expire)         timeout  <= 1'b1;
    end
  end
`else
  assign idle_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ebreak_hit = 1'b0;
    case (state_q)
      RUN: begin
        if (hs && Ins5 == EBREAK_INS) begin
          state_d    = HALT;
          ebreak_hit = 1'b1;
        end else if (idle_expire) begin
          state_d = HALT;
        end
      end
      HALT: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_ins   <= '0;
      commit_wen   <= 1'b0;
      commit_rd    <= '0;
      commit_data  <= '0;
      halt         <= 1'b0;
      good_trap    <= 1'b0;
      cycle_cnt    <= '0;
      instret      <= '0;
    end else begin
      commit_valid <= hs;
      if (hs) begin
        commit_pc   <= PC6;
        commit_ins  <= Ins5;
        commit_wen  <= reg_w_en4 && (rdest3 != 5'd0);
        commit_rd   <= rdest3;
        commit_data <= WB_data1;
        instret     <= instret + 64'd1;
      end
      if (state_q == RUN) cycle_cnt <= cycle_cnt + 64'd1;
      if (ebreak_hit) begin
        halt      <= 1'b1;
        good_trap <= (a0_data == '0);
      end
      if (idle_expire) begin
        halt      <= 1'b1;
        good_trap <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_wb_stage.sv
// Scoreboard bench for ysyx_22041071_wb_stage: expected commits are queued when
// driven and compared when commit_valid appears; a small model tracks rf/counters.
module tb_ysyx_22041071_wb_stage;
  import ysyx_22041071_wb_stage_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid6, ready6, reg_w_en4;
  logic [63:0]     PC6, WB_data1, rs1_data, rs2_data;
  logic [31:0]     Ins5;
  logic [4:0]      rdest3, rs1_addr, rs2_addr;
  logic            commit_valid, commit_wen, halt, good_trap, timeout;
  logic [63:0]     commit_pc, commit_data, cycle_cnt, instret;
  logic [31:0]     commit_ins;
  logic [4:0]      commit_rd;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [63:0] inst;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] m_rf [32];
  logic        m_halt = 1'b0;
  logic        m_good = 1'b0;
  logic        m_to   = 1'b0;
  logic [63:0] m_cyc  = '0;
  logic [63:0] m_inst = '0;

  ysyx_22041071_wb_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .valid6(valid6), .ready6(ready6), .PC6(PC6),
    .Ins5(Ins5), .reg_w_en4(reg_w_en4), .rdest3(rdest3), .WB_data1(WB_data1),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_ins(commit_ins),
    .commit_wen(commit_wen), .commit_rd(commit_rd), .commit_data(commit_data),
    .halt(halt), .good_trap(good_trap), .cycle_cnt(cycle_cnt), .instret(instret),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] a, input logic wen,
                                         input logic [4:0] rd, input logic [63:0] d);
    if (a == 5'd0) return '0;
    if (wen && rd == a) return d;
    return m_rf[a];
  endfunction

  // Model cycle counter: counts every RUN edge, cleared by reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) m_cyc = '0;
    else if (!m_halt) m_cyc = m_cyc + 64'd1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset && commit_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL commit_unexpected: got pc %h, expected no commit", commit_pc);
      end else begin
        e = sb.pop_front();
        check("commit_pc",   commit_pc,   e.pc);
        check("commit_ins",  {32'd0, commit_ins}, {32'd0, e.ins});
        check("commit_wen",  {63'd0, commit_wen}, {63'd0, e.wen && e.rd != 5'd0});
        check("commit_rd",   {59'd0, commit_rd},  {59'd0, e.rd});
        check("commit_data", commit_data, e.data);
        check("instret",     instret,     e.inst);
        check("cycle_cnt",   cycle_cnt,   m_cyc);
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_halt = 1'b0;
    m_good = 1'b0;
    m_to   = 1'b0;
    m_inst = '0;
    sb.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset  = 1'b0;
    valid6 = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_halt"},    {63'd0, halt},      {63'd0, m_halt});
    check({tag, "_good"},    {63'd0, good_trap}, {63'd0, m_good});
    check({tag, "_ready6"},  {63'd0, ready6},    {63'd0, !m_halt});
    check({tag, "_timeout"}, {63'd0, timeout},   {63'd0, m_to});
    check({tag, "_instret"}, instret,  m_inst);
    check({tag, "_cycles"},  cycle_cnt, m_cyc);
  endtask

  task automatic send(input logic [63:0] pc, input logic [31:0] ins, input logic wen,
                      input logic [4:0] rd, input logic [63:0] d,
                      input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    @(negedge clk);
    valid6 = 1'b1; PC6 = pc; Ins5 = ins; reg_w_en4 = wen; rdest3 = rd; WB_data1 = d;
    rs1_addr = a1; rs2_addr = a2;
    #1;
    check("ready6",   {63'd0, ready6}, 64'd1);
    check("rs1_data", rs1_data, exp_rd(a1, wen, rd, d));
    check("rs2_data", rs2_data, exp_rd(a2, wen, rd, d));
    m_inst = m_inst + 64'd1;
    e = '{pc, ins, wen, rd, d, m_inst};
    sb.push_back(e);
    if (ins == EBREAK_INS) m_good = (exp_rd(REG_A0, wen, rd, d) == '0);
    @(posedge clk);
    #1;
    if (wen && rd != 5'd0) m_rf[rd] = d;
    if (ins == EBREAK_INS) m_halt = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid6 = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [63:0] pc;
    reset = 1'b0; valid6 = 1'b0; PC6 = '0; Ins5 = '0; reg_w_en4 = 1'b0;
    rdest3 = '0; WB_data1 = '0; rs1_addr = '0; rs2_addr = '0;
    clear_model();
    repeat (2) @(negedge clk);
    check("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
    check("rst_commit_pc", commit_pc, 64'd0);
    check_status("rst");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("cycle_cnt_3", cycle_cnt, 64'd3);

`ifdef YSYX_22041071_WB_TIMEOUT_EN
    apply_reset();
    repeat (7) @(negedge clk);
    check("to_before_limit", {63'd0, timeout}, 64'd0);
    @(negedge clk);
    m_to = 1'b1; m_halt = 1'b1;
    check_status("to_fired");
    apply_reset();
    repeat (6) @(negedge clk);
    send(64'h100, 32'h13, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    repeat (2) begin
      @(negedge clk);
      valid6 = 1'b0;
      check_status("to_saved");
    end
`endif

    apply_reset();
    send(64'h8000_0000, 32'h0000_0013, 1'b1, 5'd5, 64'h1234, 5'd0, 5'd0);
    send(64'h8000_0004, 32'h0000_0013, 1'b1, 5'd7, 64'hDEAD, 5'd5, 5'd7);
    check("bypass_x7", rs2_data, 64'hDEAD);
    send(64'h8000_0008, 32'h0000_0013, 1'b1, 5'd0, 64'hFFFF, 5'd0, 5'd7);
    check("x0_read", rs1_data, 64'd0);
    idle(1);
    rs1_addr = 5'd5;
    #1 check("x5_read", rs1_data, 64'h1234);

    pc = 64'h8000_0100;
    for (int i = 0; i < 12; i++) begin
      send(pc, 32'h13 | ($urandom & 32'hFFFF_F000), 1'($urandom_range(1)),
           5'($urandom_range(31)), {$urandom, $urandom},
           5'($urandom_range(31)), 5'($urandom_range(31)));
      pc = pc + 64'd4;
    end
    idle(2);
    check_status("burst");

    send(64'h8000_0200, 32'h13, 1'b1, REG_A0, 64'd0, 5'd0, 5'd0);
    send(64'h8000_0204, EBREAK_INS, 1'b0, 5'd0, 64'd0, REG_A0, 5'd0);
    idle(2);
    check("good_trap_a0_zero", {63'd0, good_trap}, 64'd1);
    check_status("halt_good");
    repeat (3) begin
      @(negedge clk);
      valid6 = 1'b1; PC6 = 64'hBAD; Ins5 = 32'h13;
      #1 check("ready6_halted", {63'd0, ready6}, 64'd0);
    end
    idle(1);
    check_status("halt_frozen");

    apply_reset();
    send(64'h8000_0300, 32'h13, 1'b1, REG_A0, 64'd3, 5'd0, 5'd0);
    send(64'h8000_0304, EBREAK_INS, 1'b0, 5'd0, 64'd0, REG_A0, 5'd0);
    idle(2);
    check("good_trap_a0_three", {63'd0, good_trap}, 64'd0);
    check_status("halt_bad");

    @(negedge clk);
    valid6 = 1'b1; reg_w_en4 = 1'b1; rdest3 = 5'd12; WB_data1 = 64'h55; Ins5 = 32'h13;
    #2 reset = 1'b0;
    clear_model();
    #1;
    check_status("mid_rst");
    check("mid_rst_commit_valid", {63'd0, commit_valid}, 64'd0);
    rs1_addr = REG_A0;
    #1 check("mid_rst_a0", rs1_data, 64'd0);
    @(negedge clk);
    valid6 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rs1_addr = 5'd12;
    #1 check("no_partial_write", rs1_data, 64'd0);
    idle(2);
    check_status("post_rst");
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
